// File: rtl/shift_register_pkg.sv
// Shared types and constants for the latched shift-register driver.
package shift_register_pkg;

   localparam int CLK_DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      LATCH
   } sr_state_t;

endpackage

// File: rtl/sr_phase_tick.sv
// Phase timer: counts 0..CLK_DIV-1 while run is high and flags the last cycle of a phase.
module sr_phase_tick
   import shift_register_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam logic [CLK_DIV_W-1:0] LAST = CLK_DIV_W'(CLK_DIV - 1);

   logic [CLK_DIV_W-1:0] count;

   // Held at zero while idle so the first phase of a frame is always full length.
   assign tick = run && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!run || tick) begin
         count <= '0;
      end else begin
         count <= count + CLK_DIV_W'(1);
      end
   end

endmodule

// File: rtl/shift_register_driver.sv
// Serializes a parallel frame LSB first into a latched shift register (SER/SRCLK/RCLK).
//
// state    | meaning
// IDLE     | waiting for a frame, ready=1, ser=0
// SETUP    | ser presents the current bit, shclk=0
// SHIFT_HI | shclk=1, downstream shifts the current bit in
// LATCH    | rclk=1, downstream copies its shift register to Q
module shift_register_driver
   import shift_register_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 2
) (
   input  logic             SRCLK,
   input  logic             SRCLR_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             ser,
   output logic             shclk,
   output logic             rclk,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   sr_state_t        state;
   sr_state_t        state_d;
   logic [BIT_W-1:0] bit_cnt;
   logic [BIT_W-1:0] bit_cnt_d;
   logic [WIDTH-1:0] frame;
   logic [WIDTH-1:0] frame_d;
   logic             ser_d;
   logic             run;
   logic             tick;

   assign run = (state != IDLE);

   sr_phase_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_phase (
      .clk  (SRCLK),
      .rst_n(SRCLR_n),
      .run  (run),
      .tick (tick)
   );

   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      frame_d   = frame;
      ser_d     = ser;
      unique case (state)
         IDLE: begin
            if (valid) begin
               state_d   = SETUP;
               frame_d   = data_in;
               ser_d     = data_in[0];
               bit_cnt_d = '0;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               bit_cnt_d = bit_cnt + BIT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  state_d = LATCH;
                  ser_d   = 1'b0;
               end else begin
                  // The frame register shifts so the next bit is always at index 0.
                  state_d = SETUP;
                  frame_d = frame >> 1;
                  ser_d   = frame_d[0];
               end
            end
         end
         LATCH: begin
            if (tick) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so each pin changes on the same edge as the state.
   always_ff @(posedge SRCLK or negedge SRCLR_n) begin
      if (!SRCLR_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         frame   <= '0;
         ser     <= 1'b0;
         shclk   <= 1'b0;
         rclk    <= 1'b0;
         done    <= 1'b0;
         ready   <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         bit_cnt <= bit_cnt_d;
         frame   <= frame_d;
         ser     <= ser_d;
         shclk   <= (state_d == SHIFT_HI);
         rclk    <= (state_d == LATCH);
         done    <= (state == LATCH) && (state_d == IDLE);
         ready   <= (state_d == IDLE);
         busy    <= (state_d != IDLE);
      end
   end

endmodule

// File: doc/shift_register_driver.md
SHIFT_REGISTER_DRIVER -- requirements
Module: shift_register_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits per frame, equal to the width of the downstream latched shift register.
REQ-002 SHALL have parameter CLK_DIV, default 2: system cycles per shift-clock phase, legal range 1..255.
REQ-003 SHALL have port SRCLK, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port SRCLR_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port data_in, input, WIDTH bits: parallel frame to serialize.
REQ-006 SHALL have port valid, input, 1 bit: data_in is valid.
REQ-007 SHALL have port ready, output, 1 bit: driver can accept a frame.
REQ-008 SHALL have port ser, output, 1 bit: serial data to the downstream SER pin.
REQ-009 SHALL have port shclk, output, 1 bit: shift clock to the downstream SRCLK pin.
REQ-010 SHALL have port rclk, output, 1 bit: latch strobe to the downstream RCLK pin.
REQ-011 SHALL have port busy, output, 1 bit: frame in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a frame is latched and the driver is idle again.

Function
REQ-013 SHALL accept a frame only in a cycle T where valid and ready are both 1, capturing data_in into an internal frame register in that cycle.
REQ-014 SHALL ignore valid while ready is 0; data_in changes after T SHALL NOT affect the frame in flight.
REQ-015 SHALL send bits LSB first, so data_in[0] ends at downstream Q[0] after WIDTH shifts into the right-shifting register.
REQ-016 SHALL use FSM states IDLE -> SETUP -> SHIFT_HI -> (SETUP for the next bit | LATCH) -> IDLE; no other states.
REQ-017 SHALL use a phase counter that counts 0..CLK_DIV-1; each of SETUP, SHIFT_HI and LATCH SHALL last exactly CLK_DIV cycles.
REQ-018 SHALL drive ser = bit i for all of SETUP(i) and SHIFT_HI(i), with shclk=0 in SETUP and shclk=1 in SHIFT_HI; ser SHALL be stable for CLK_DIV cycles before each shclk rising edge.
REQ-019 SHALL satisfy bit i timing: ser valid from T+1+2*i*CLK_DIV, and shclk rising at T+1+(2*i+1)*CLK_DIV.
REQ-020 SHALL, after SHIFT_HI of bit WIDTH-1, enter LATCH with shclk=0 and rclk=1 for CLK_DIV cycles, starting at T+1+2*WIDTH*CLK_DIV.
REQ-021 SHALL return to IDLE at T+1+(2*WIDTH+1)*CLK_DIV, with done=1 for that single cycle and ready=1 from that cycle onward.
REQ-022 SHALL drive ready = (state==IDLE) and busy = !ready; back-to-back frames are allowed, so valid held high in the done cycle starts the next frame.
REQ-023 SHALL keep ser at 0 in IDLE and LATCH.
REQ-024 SHALL use a bit counter of width $clog2(WIDTH+1) and a phase counter of width 8, with no wrap beyond their terminal values.

Reset
REQ-025 SHALL, on SRCLR_n=0, immediately force state=IDLE, ser=0, shclk=0, rclk=0, done=0, ready=1, busy=0, and clear both counters and the frame register.
REQ-026 SHALL, if reset asserts mid-frame, abandon the frame without issuing rclk; the downstream latch keeps its previous contents.
REQ-027 SHALL accept a new frame in the first cycle after reset deassertion.

Structure
REQ-028 SHALL define the FSM state typedef and the CLK_DIV width constant in shared package shift_register_pkg.
REQ-029 SHALL implement the phase counter as sub-module sr_phase_tick (inputs clk, rst_n, run; output tick when the count reaches CLK_DIV-1).
REQ-030 SHALL register all outputs, with no combinational path from valid to ser, shclk or rclk.

Verification
REQ-031 SHALL cover a single frame: WIDTH=8, CLK_DIV=2, data_in=8'hA5 -> 8 shclk rises at T+3, T+7, ..., T+31; rclk high T+33..T+34; done at T+35; downstream Q=8'hA5 after rclk.
REQ-032 SHALL cover back-to-back frames: valid held high with 8'h01 then 8'h80 -> second frame accepted in the done cycle; Q=8'h01, then 8'h80; no idle gap.
REQ-033 SHALL cover CLK_DIV=1 with data_in=8'hFF -> shclk toggles every cycle; rclk high for exactly 1 cycle at T+17; done at T+18.
REQ-034 SHALL cover reset mid-frame: SRCLR_n low after 3 shclk rises -> all outputs at reset values in the same cycle; no rclk pulse; previous Q unchanged.
REQ-035 SHALL cover valid while busy: data_in changes and valid pulses during a frame -> ignored; the transmitted frame equals the captured value.
REQ-036 SHALL cover WIDTH=16 with data_in=16'h8001 -> 16 shclk rises; downstream Q=16'h8001; done at T+1+33*CLK_DIV.
